count_ctrl: RTL and testbench
=============================

Name: count_ctrl

Overview:
- Drives the EN and MAX inputs of the lab standard counter, and consumes that counter's RCO (rollover) flag.
- Generates a programmable-rate single-cycle EN strobe and holds a stable MAX value for the duration of a run.
- Counts counter wraps and ends the run after a programmed number of wraps, or on command.
- Sits between top-level switch/button logic and the counter instance.

Parameters:
WIDTH, 8, width of MAX_IN/MAX (counter terminal value)
DIV_W, 16, width of the prescale divisor DIV
WRAPS_W, 8, width of WRAPS and WRAP_CNT

Ports:
clk  input  1  system clock, all logic on rising edge
RST  input  1  synchronous active-high reset
START  input  1  start request, sampled in IDLE only
STOP  input  1  abort request, sampled in RUN only
DIV  input  DIV_W  EN strobe period in clk cycles; 0 treated as 1
MAX_IN  input  WIDTH  terminal count for the run
WRAPS  input  WRAPS_W  number of wraps before done; 0 = run until STOP
RCO  input  1  counter rollover flag (count == MAX while EN high)
EN  output  1  counter enable strobe, one cycle wide
MAX  output  WIDTH  registered terminal count to counter
BUSY  output  1  high in RUN
DONE  output  1  one-cycle pulse when WRAPS wraps complete
WRAP_CNT  output  WRAPS_W  wraps counted in current/last run

Behaviour:
- Reset (RST high at clk edge): state IDLE, EN=0, MAX=0, BUSY=0, DONE=0, WRAP_CNT=0, prescaler=0, latched DIV/WRAPS=0. Reset wins over every other input, in any state.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - START=1 and STOP=0 -> RUN next cycle.
  - On that edge: latch MAX<=MAX_IN, div_q<=max(DIV,1), wraps_q<=WRAPS; clear WRAP_CNT and prescaler.
  - START=1 with STOP=1 -> stay IDLE (STOP wins).
  - MAX and WRAP_CNT hold their last values in IDLE.
- RUN:
  - BUSY=1.
  - Prescaler increments each cycle. When prescaler == div_q-1, EN=1 for that cycle and the prescaler wraps to 0.
  - First EN appears div_q cycles after the START edge. Example: DIV=1 gives EN every cycle starting the cycle after BUSY rises; DIV=3 gives EN on cycles 3, 6, 9 after START.
  - DIV, MAX_IN and WRAPS changes during RUN are ignored.
  - A wrap is counted only when RCO=1 and EN=1 in the same cycle; RCO without EN is ignored.
  - WRAP_CNT saturates at all-ones when wraps_q=0.
  - If wraps_q!=0 and a counted wrap makes WRAP_CNT == wraps_q -> go to DONE. EN is low from the next cycle.
  - STOP=1 -> IDLE next cycle, EN=0, no DONE pulse, WRAP_CNT holds.
  - STOP coincident with the final counted wrap -> DONE (completion wins).
  - START in RUN is ignored.
- DONE: lasts exactly one cycle. DONE=1, BUSY=0, EN=0, then IDLE unconditionally. START during DONE is ignored.
- Arithmetic:
  - Prescaler is DIV_W bits; comparison against div_q-1 is unsigned.
  - DIV = all-ones is legal: period 2^DIV_W-1.

Optional Feature:
- Macro: COUNT_CTRL_PAUSE_EN
- With the macro defined:
  - Adds input port PAUSE (1 bit).
  - In RUN with PAUSE=1: EN is forced 0, the prescaler and WRAP_CNT freeze, and RCO is ignored.
  - Releasing PAUSE resumes the prescaler from its frozen value.
  - STOP and RST still act while paused.
  - PAUSE has no effect in IDLE or DONE.
- Without the macro: no PAUSE port; RUN behaviour as above.

Test Plan:
- Reset: RST for 2 cycles mid-RUN (DIV=2) -> next cycle IDLE, EN=0, BUSY=0, MAX=0, WRAP_CNT=0.
- Strobe rate: MAX_IN=5, DIV=4, WRAPS=0, START pulse -> EN high on cycles 4, 8, 12 after START; MAX=5 stable; BUSY=1.
- Done: DIV=1, WRAPS=3, bench drives RCO with EN every 6th EN -> WRAP_CNT 1, 2, 3, one-cycle DONE on the cycle after the 3rd wrap, then IDLE; no EN after.
- Abort and conflicts:
  - STOP in RUN after 2 wraps -> IDLE, DONE never asserts, WRAP_CNT=2.
  - START+STOP together in IDLE -> stays IDLE.
- Edge cases:
  - DIV=0 -> EN every cycle.
  - RCO high while EN low -> WRAP_CNT unchanged.
  - STOP coincident with final wrap -> DONE pulses.
- Pause (COUNT_CTRL_PAUSE_EN): DIV=4, PAUSE high for 10 cycles after the 1st EN -> no EN during pause; next EN 3 cycles after PAUSE falls.

Source files
------------

// File: rtl/count_ctrl.sv
// Run controller for the lab counter: programmable-rate EN strobe, stable MAX, wrap counting.
// Optional PAUSE input enabled by defining COUNT_CTRL_PAUSE_EN.
module count_ctrl #(
   parameter int WIDTH   = 8,
   parameter int DIV_W   = 16,
   parameter int WRAPS_W = 8
) (
   input  logic               clk,
   input  logic               RST,
   input  logic               START,
   input  logic               STOP,
   input  logic [DIV_W-1:0]   DIV,
   input  logic [WIDTH-1:0]   MAX_IN,
   input  logic [WRAPS_W-1:0] WRAPS,
   input  logic               RCO,
`ifdef COUNT_CTRL_PAUSE_EN
   input  logic               PAUSE,
`endif
   output logic               EN,
   output logic [WIDTH-1:0]   MAX,
   output logic               BUSY,
   output logic               DONE,
   output logic [WRAPS_W-1:0] WRAP_CNT
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [DIV_W-1:0]   DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0]   DIV_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [WRAPS_W-1:0] WRAP_ZERO = {WRAPS_W{1'b0}};
   localparam logic [WRAPS_W-1:0] WRAP_ONE  = {{(WRAPS_W-1){1'b0}}, 1'b1};
   localparam logic [WRAPS_W-1:0] WRAP_SAT  = {WRAPS_W{1'b1}};
   localparam logic [WIDTH-1:0]   MAX_ZERO  = {WIDTH{1'b0}};

   logic [1:0]         state;
   logic [DIV_W-1:0]   prescaler;
   logic [DIV_W-1:0]   div_q;
   logic [WRAPS_W-1:0] wraps_q;
   logic               paused;
   logic               wrap_hit;
   logic               final_wrap;
   logic               strobe;
   logic [WRAPS_W-1:0] wrap_next;

`ifdef COUNT_CTRL_PAUSE_EN
   assign paused = PAUSE;
`else
   assign paused = 1'b0;
`endif

   // A wrap counts only when the counter saw our EN strobe; the count saturates.
   always_comb begin
      wrap_hit = EN & RCO & ~paused;
      if (wrap_hit && (WRAP_CNT != WRAP_SAT)) begin
         wrap_next = WRAP_CNT + WRAP_ONE;
      end else begin
         wrap_next = WRAP_CNT;
      end
      final_wrap = wrap_hit && (wraps_q != WRAP_ZERO) && (wrap_next == wraps_q);
      strobe     = (prescaler == (div_q - DIV_ONE));
   end

   // Run state machine and all registered outputs.
   always_ff @(posedge clk) begin
      if (RST) begin
         state     <= S_IDLE;
         EN        <= 1'b0;
         MAX       <= MAX_ZERO;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         WRAP_CNT  <= WRAP_ZERO;
         prescaler <= DIV_ZERO;
         div_q     <= DIV_ZERO;
         wraps_q   <= WRAP_ZERO;
      end else begin
         case (state)
            S_IDLE: begin
               EN   <= 1'b0;
               DONE <= 1'b0;
               if (START && !STOP) begin
                  state     <= S_RUN;
                  BUSY      <= 1'b1;
                  MAX       <= MAX_IN;
                  div_q     <= (DIV == DIV_ZERO) ? DIV_ONE : DIV;
                  wraps_q   <= WRAPS;
                  WRAP_CNT  <= WRAP_ZERO;
                  prescaler <= DIV_ZERO;
               end else begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
               end
            end
            S_RUN: begin
               DONE <= 1'b0;
               // Completion takes priority over a simultaneous STOP.
               if (final_wrap) begin
                  state    <= S_DONE;
                  WRAP_CNT <= wrap_next;
                  DONE     <= 1'b1;
                  BUSY     <= 1'b0;
                  EN       <= 1'b0;
               end else if (STOP) begin
                  state <= S_IDLE;
                  BUSY  <= 1'b0;
                  EN    <= 1'b0;
               end else if (paused) begin
                  EN <= 1'b0;
               end else begin
                  WRAP_CNT  <= wrap_next;
                  EN        <= strobe;
                  prescaler <= strobe ? DIV_ZERO : (prescaler + DIV_ONE);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               EN    <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               EN    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: vector table, directed corner sequences, random run vs reference model.
// Define COUNT_CTRL_PAUSE_EN for both files to exercise the PAUSE input.
module tb_count_ctrl;
   localparam int WIDTH   = 8;
   localparam int DIV_W   = 16;
   localparam int WRAPS_W = 8;
   localparam int CNT_MAX = (1 << WRAPS_W) - 1;

   logic clk = 1'b0;
   logic RST, START, STOP, RCO;
   logic [DIV_W-1:0]   DIV;
   logic [WIDTH-1:0]   MAX_IN;
   logic [WRAPS_W-1:0] WRAPS;
`ifdef COUNT_CTRL_PAUSE_EN
   logic PAUSE;
`endif
   logic EN, BUSY, DONE;
   logic [WIDTH-1:0]   MAX;
   logic [WRAPS_W-1:0] WRAP_CNT;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: position in the run is tracked as a count of active cycles.
   int m_state, m_en, m_max, m_busy, m_done, m_cnt, m_div, m_wraps, m_active;

   count_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W), .WRAPS_W(WRAPS_W)) dut (
      .clk(clk), .RST(RST), .START(START), .STOP(STOP), .DIV(DIV),
      .MAX_IN(MAX_IN), .WRAPS(WRAPS), .RCO(RCO),
`ifdef COUNT_CTRL_PAUSE_EN
      .PAUSE(PAUSE),
`endif
      .EN(EN), .MAX(MAX), .BUSY(BUSY), .DONE(DONE), .WRAP_CNT(WRAP_CNT)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, start, stop, rco;
      logic [DIV_W-1:0] div;
      logic [WIDTH-1:0] max_in;
      logic [WRAPS_W-1:0] wraps;
      logic en, busy, done;
      logic [WRAPS_W-1:0] cnt;
      logic [WIDTH-1:0] max;
   } vec_t;

   vec_t vt[17];

   function automatic vec_t mk(input logic rst, start, stop, rco, input int div, max_in, wraps,
                               input logic en, busy, done, input int cnt, max);
      vec_t v;
      v.rst = rst; v.start = start; v.stop = stop; v.rco = rco;
      v.div = DIV_W'(div); v.max_in = WIDTH'(max_in); v.wraps = WRAPS_W'(wraps);
      v.en = en; v.busy = busy; v.done = done;
      v.cnt = WRAPS_W'(cnt); v.max = WIDTH'(max);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_step();
      int  newcnt;
      bit  hit;
      bit  pz;
`ifdef COUNT_CTRL_PAUSE_EN
      pz = PAUSE;
`else
      pz = 1'b0;
`endif
      if (RST) begin
         m_state = 0; m_en = 0; m_max = 0; m_busy = 0; m_done = 0;
         m_cnt = 0; m_div = 0; m_wraps = 0; m_active = 0;
      end else if (m_state == 0) begin
         m_en = 0; m_done = 0;
         if (START && !STOP) begin
            m_state = 1; m_busy = 1; m_max = int'(MAX_IN);
            m_div = (DIV == 0) ? 1 : int'(DIV);
            m_wraps = int'(WRAPS); m_cnt = 0; m_active = 0;
         end
      end else if (m_state == 1) begin
         hit = (m_en != 0) && RCO && !pz;
         newcnt = (hit && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
         if (hit && m_wraps != 0 && newcnt == m_wraps) begin
            m_cnt = newcnt; m_state = 2; m_done = 1; m_busy = 0; m_en = 0;
         end else if (STOP) begin
            m_state = 0; m_busy = 0; m_en = 0;
         end else if (pz) begin
            m_en = 0;
         end else begin
            m_cnt = newcnt;
            m_active++;
            m_en = ((m_active % m_div) == 0) ? 1 : 0;
         end
      end else begin
         m_state = 0; m_done = 0; m_en = 0; m_busy = 0;
      end
   endfunction

   // One clock: advance the model with the inputs seen at the edge, then compare.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("model_en", EN, m_en);
      chk("model_busy", BUSY, m_busy);
      chk("model_done", DONE, m_done);
      chk("model_max", MAX, m_max);
      chk("model_wrap_cnt", WRAP_CNT, m_cnt);
   endtask

   task automatic do_reset();
      RST = 1'b1; START = 1'b0; STOP = 1'b0; RCO = 1'b0;
      tick();
      RST = 1'b0;
   endtask

   task automatic start_run(input int div, input int max_in, input int wraps);
      DIV = DIV_W'(div); MAX_IN = WIDTH'(max_in); WRAPS = WRAPS_W'(wraps);
      START = 1'b1;
      tick();
      START = 1'b0;
   endtask

   initial begin
      RST = 1'b1; START = 1'b0; STOP = 1'b0; RCO = 1'b0;
      DIV = '0; MAX_IN = '0; WRAPS = '0;
`ifdef COUNT_CTRL_PAUSE_EN
      PAUSE = 1'b0;
`endif

      // Vector table: reset, DIV=4 strobe rate with ignored input changes, STOP, START+STOP in IDLE.
      vt[0] = mk(1, 0, 0, 0, 4, 5, 0, 0, 0, 0, 0, 0);
      vt[1] = mk(0, 1, 0, 0, 4, 5, 0, 0, 1, 0, 0, 5);
      for (int i = 2; i <= 13; i++)
         vt[i] = mk(0, 0, 0, 0, 1, 9, 2, ((i - 1) % 4) == 0, 1, 0, 0, 5);
      vt[14] = mk(0, 0, 1, 0, 4, 5, 0, 0, 0, 0, 0, 5);
      vt[15] = mk(0, 1, 1, 0, 4, 7, 0, 0, 0, 0, 0, 5);
      vt[16] = mk(0, 0, 0, 1, 4, 7, 0, 0, 0, 0, 0, 5);
      for (int i = 0; i < 17; i++) begin
         RST = vt[i].rst; START = vt[i].start; STOP = vt[i].stop; RCO = vt[i].rco;
         DIV = vt[i].div; MAX_IN = vt[i].max_in; WRAPS = vt[i].wraps;
         tick();
         chk($sformatf("vec%0d_en", i), EN, vt[i].en);
         chk($sformatf("vec%0d_busy", i), BUSY, vt[i].busy);
         chk($sformatf("vec%0d_done", i), DONE, vt[i].done);
         chk($sformatf("vec%0d_cnt", i), WRAP_CNT, vt[i].cnt);
         chk($sformatf("vec%0d_max", i), MAX, vt[i].max);
      end

      // Done: DIV=1, WRAPS=3, RCO on every 6th EN.
      do_reset();
      start_run(1, 6, 3);
      for (int e = 1; e <= 22; e++) begin
         tick();
         chk($sformatf("done_seq_en%0d", e), EN, (e <= 18) ? 1 : 0);
         chk($sformatf("done_seq_busy%0d", e), BUSY, (e <= 18) ? 1 : 0);
         chk($sformatf("done_seq_done%0d", e), DONE, (e == 19) ? 1 : 0);
         chk($sformatf("done_seq_cnt%0d", e), WRAP_CNT, (e >= 19) ? 3 : (e >= 13) ? 2 : (e >= 7) ? 1 : 0);
         RCO = ((e % 6) == 0) && (e <= 18);
      end
      RCO = 1'b0;

      // Abort after two wraps.
      do_reset();
      start_run(1, 3, 5);
      for (int e = 1; e <= 6; e++) begin
         tick();
         RCO = (e == 2) || (e == 4);
      end
      chk("abort_cnt_before", WRAP_CNT, 2);
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
      chk("abort_busy", BUSY, 0);
      chk("abort_done", DONE, 0);
      chk("abort_cnt", WRAP_CNT, 2);
      tick();
      chk("abort_done_after", DONE, 0);
      chk("abort_en_after", EN, 0);

      // STOP coincident with the final wrap: completion wins.
      do_reset();
      start_run(1, 3, 1);
      tick();
      RCO = 1'b1; STOP = 1'b1;
      tick();
      RCO = 1'b0; STOP = 1'b0;
      chk("stopfinal_done", DONE, 1);
      chk("stopfinal_cnt", WRAP_CNT, 1);
      tick();
      chk("stopfinal_done_end", DONE, 0);

      // RCO while EN is low must not count.
      do_reset();
      start_run(3, 3, 0);
      RCO = 1'b1;
      for (int e = 1; e <= 4; e++) begin
         tick();
         chk($sformatf("rco_noen_cnt%0d", e), WRAP_CNT, (e == 4) ? 1 : 0);
      end
      RCO = 1'b0;

      // DIV=0 behaves as DIV=1.
      do_reset();
      start_run(0, 3, 0);
      for (int e = 1; e <= 5; e++) begin
         tick();
         chk($sformatf("div0_en%0d", e), EN, 1);
      end

      // Reset held for two cycles mid-run.
      do_reset();
      start_run(2, 9, 0);
      for (int e = 1; e <= 5; e++) tick();
      RST = 1'b1;
      for (int e = 0; e < 2; e++) begin
         tick();
         chk("midrst_en", EN, 0);
         chk("midrst_busy", BUSY, 0);
         chk("midrst_max", MAX, 0);
         chk("midrst_cnt", WRAP_CNT, 0);
      end
      RST = 1'b0;
      tick();
      chk("midrst_idle_busy", BUSY, 0);

`ifdef COUNT_CTRL_PAUSE_EN
      // Pause for 10 cycles after the first EN; next EN 3 cycles after release.
      do_reset();
      start_run(4, 3, 0);
      for (int e = 1; e <= 5; e++) begin
         tick();
         chk($sformatf("pause_pre_en%0d", e), EN, (e == 4) ? 1 : 0);
      end
      PAUSE = 1'b1; RCO = 1'b1;
      for (int e = 6; e <= 15; e++) begin
         tick();
         chk($sformatf("pause_en%0d", e), EN, 0);
         chk($sformatf("pause_cnt%0d", e), WRAP_CNT, 0);
      end
      PAUSE = 1'b0; RCO = 1'b0;
      for (int e = 16; e <= 18; e++) begin
         tick();
         chk($sformatf("pause_post_en%0d", e), EN, (e == 18) ? 1 : 0);
      end
`endif

      // Randomized run against the reference model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         RST    = ($urandom_range(0, 149) == 0);
         START  = ($urandom_range(0, 7) == 0);
         STOP   = ($urandom_range(0, 39) == 0);
         RCO    = ($urandom_range(0, 2) == 0);
         DIV    = DIV_W'($urandom_range(0, 4));
         MAX_IN = WIDTH'($urandom);
         WRAPS  = WRAPS_W'($urandom_range(0, 3));
`ifdef COUNT_CTRL_PAUSE_EN
         PAUSE  = ($urandom_range(0, 7) == 0);
`endif
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
